// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: default bit divisor, status bit positions, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_rx_pkg;

   // 32 MHz system clock / 115200 baud
   localparam int DIVISOR_DEF  = 277;

   // Status word bit positions
   localparam int RX_VALID_BIT = 15;
   localparam int OVR_BIT      = 14;
   localparam int FERR_BIT     = 13;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO with wrapping pointers and a separate occupancy counter.
// Latency: push visible at dout/level one clk after the push edge; dout is the head combinationally.
// Backpressure: push when full is ignored unless a pop happens in the same cycle; pop when empty is ignored.
//
// Ports:
//   clk, reset_b      clock, async active-low reset (empties the FIFO)
//   push, din         write strobe and data
//   pop               read strobe (advances the head)
//   dout              current head entry (stale when empty)
//   full, empty       occupancy flags
//   level             occupancy 0..DEPTH
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int LVL_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset_b,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (level_q == LVL_W'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign dout    = mem_q[rd_ptr_q];

   assign do_pop  = pop && !empty;
   // A pop frees a slot in the same cycle, so a push onto a full FIFO still lands.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver with a small receive FIFO on a shared 16-bit tri-state bus.
// Latency: rxd->FSM 2 clk; byte enters FIFO 1 clk after the mid-stop-bit sample.
// Backpressure: none on the line; a byte arriving at a full FIFO is dropped and sets ovr.
//
// Ports:
//   clk      system clock
//   reset_b  async active-low reset
//   data     16-bit CPU bus, driven only while !cs_b && rnw
//   a0       register select: 0 = status, 1 = receive data
//   rnw      1 = read, 0 = write
//   cs_b     active-low chip select
//   rxd      asynchronous serial input, idles high
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int DIVISOR    = DIVISOR_DEF,
   parameter int CNT_W      = 9,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_b,
   inout  wire  [15:0] data,
   input  logic        a0,
   input  logic        rnw,
   input  logic        cs_b,
   input  logic        rxd
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIVISOR / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIVISOR - 1);

   // Two-flop synchronizer; rxs_q is the only view of the line.
   logic rxd_meta_q;
   logic rxs_q;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         rxd_meta_q <= 1'b1;
         rxs_q      <= 1'b1;
      end else begin
         rxd_meta_q <= rxd;
         rxs_q      <= rxd_meta_q;
      end
   end

   // Receive FSM with registered push / framing-error strobes.
   rx_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       idx_q;
   logic [7:0]       sr_q;
   logic             push_q;
   logic             ferr_set_q;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         sr_q       <= '0;
         push_q     <= 1'b0;
         ferr_set_q <= 1'b0;
      end else begin
         push_q     <= 1'b0;
         ferr_set_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (!rxs_q) begin
                  // Half a bit time lands the next sample mid start bit.
                  state_q <= ST_START;
                  cnt_q   <= CNT_HALF;
               end
            end
            ST_START: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (!rxs_q) begin
                  state_q <= ST_DATA;
                  cnt_q   <= CNT_FULL;
                  idx_q   <= '0;
               end else begin
                  // Start bit did not hold: treat as a glitch.
                  state_q <= ST_IDLE;
               end
            end
            ST_DATA: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  sr_q  <= {rxs_q, sr_q[7:1]};
                  cnt_q <= CNT_FULL;
                  if (idx_q == 3'd7) begin
                     state_q <= ST_STOP;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            ST_STOP: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else if (rxs_q) begin
                  push_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  ferr_set_q <= 1'b1;
                  state_q    <= ST_BREAK;
               end
            end
            ST_BREAK: begin
               // Hold off until the line returns high so a held-low line is one error, not many.
               if (rxs_q) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Bus access decode. A pop fires once, on the first clk of a data read.
   logic cs_b_q;
   logic pop_w;
   logic wr_stat_w;

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) cs_b_q <= 1'b1;
      else          cs_b_q <= cs_b;
   end

   assign pop_w     = !cs_b && cs_b_q && rnw && a0;
   assign wr_stat_w = !cs_b && !rnw && !a0;

   // FIFO
   logic [7:0]       fifo_dout;
   logic             fifo_full;
   logic             fifo_empty;
   logic [LVL_W-1:0] fifo_level;

   uart_rx_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_b (reset_b),
      .push    (push_q),
      .din     (sr_q),
      .pop     (pop_w),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // Sticky error flags, write-1-to-clear; a set in the same cycle wins.
   logic ovr_q, ovr_d;
   logic ferr_q, ferr_d;
   logic ovr_set_w;

   assign ovr_set_w = push_q && fifo_full && !pop_w;

   always_comb begin
      ovr_d  = ovr_q;
      ferr_d = ferr_q;
      if (wr_stat_w) begin
         if (data[OVR_BIT])  ovr_d  = 1'b0;
         if (data[FERR_BIT]) ferr_d = 1'b0;
      end
      if (ovr_set_w)  ovr_d  = 1'b1;
      if (ferr_set_q) ferr_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         ovr_q  <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         ovr_q  <= ovr_d;
         ferr_q <= ferr_d;
      end
   end

   // Read mux and tri-state drive
   logic [15:0] stat_w;
   logic [15:0] rd_dat_w;

   always_comb begin
      stat_w               = '0;
      stat_w[RX_VALID_BIT] = !fifo_empty;
      stat_w[OVR_BIT]      = ovr_q;
      stat_w[FERR_BIT]     = ferr_q;
      stat_w[7:0]          = 8'(fifo_level);
   end

   assign rd_dat_w = a0 ? {8'h00, fifo_dout} : stat_w;
   assign data     = (!cs_b && rnw) ? rd_dat_w : 16'bz;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx with a 16-clk bit time.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_rx;

   localparam int BIT_T = 16;
   localparam int FRAME = 10 * BIT_T;
   // Cycle within a frame (counted from the start-bit edge) at which the mid-stop
   // sample is taken; a read started right after it collides with the FIFO push.
   localparam int PUSH_CYC = 155;

   logic        clk = 1'b0;
   logic        reset_b;
   wire  [15:0] data;
   logic        a0;
   logic        rnw;
   logic        cs_b;
   logic        rxd;
   logic        tb_en;
   logic [15:0] tb_drv;
   logic [15:0] rd;
   logic [15:0] pop_dat;

   int checks = 0;
   int errors = 0;

   assign data = tb_en ? tb_drv : 16'bz;

   always #5 clk = ~clk;

   uart_rx #(
      .DIVISOR    (BIT_T),
      .CNT_W      (9),
      .FIFO_DEPTH (4)
   ) dut (
      .clk     (clk),
      .reset_b (reset_b),
      .data    (data),
      .a0      (a0),
      .rnw     (rnw),
      .cs_b    (cs_b),
      .rxd     (rxd)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive ncyc cycles of an 8N1 frame; optionally start a one-clk data read at pop_cyc.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input int pop_cyc, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk); #1;
         if (c < BIT_T)            rxd = 1'b0;
         else if (c < 9 * BIT_T)   rxd = b[(c - BIT_T) / BIT_T];
         else                      rxd = stop_bit;
         if (c == pop_cyc) begin
            cs_b = 1'b0; rnw = 1'b1; a0 = 1'b1;
            #1 pop_dat = data;
         end else if (c == pop_cyc + 1) begin
            cs_b = 1'b1;
         end
      end
   endtask

   task automatic bus_read(input logic sel, input int ncyc, output logic [15:0] v);
      @(posedge clk); #1;
      cs_b = 1'b0; rnw = 1'b1; a0 = sel;
      #1 v = data;
      repeat (ncyc) @(posedge clk);
      #1 cs_b = 1'b1;
   endtask

   task automatic bus_write_stat(input logic [15:0] v);
      @(posedge clk); #1;
      rnw = 1'b0; a0 = 1'b0; tb_drv = v; tb_en = 1'b1; cs_b = 1'b0;
      @(posedge clk); #1;
      cs_b = 1'b1; rnw = 1'b1; tb_en = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_b = 1'b0; rxd = 1'b1; cs_b = 1'b1; rnw = 1'b1; a0 = 1'b0;
      tb_en = 1'b0; tb_drv = '0; pop_dat = '0;
      idle(3);
      #1 reset_b = 1'b1;
      idle(4);

      bus_read(1'b0, 1, rd); check("reset_status", rd, 16'h0000);

      // 1: single frame and read
      send_frame(8'hA5, 1'b1, -1, FRAME);
      idle(4);
      bus_read(1'b0, 1, rd); check("t1_status_before", rd, 16'h8001);
      bus_read(1'b1, 1, rd); check("t1_data", rd, 16'h00A5);
      bus_read(1'b0, 1, rd); check("t1_status_after", rd, 16'h0000);

      // 2: 3-clk low glitch on idle line
      @(posedge clk); #1 rxd = 1'b0;
      idle(3); #1 rxd = 1'b1;
      idle(3 * BIT_T);
      bus_read(1'b0, 1, rd); check("t2_glitch_status", rd, 16'h0000);
      send_frame(8'h96, 1'b1, -1, FRAME);
      idle(4);
      bus_read(1'b1, 1, rd); check("t2_after_glitch_data", rd, 16'h0096);

      // 3: framing error then clear
      send_frame(8'h3C, 1'b0, -1, FRAME);
      @(posedge clk); #1 rxd = 1'b1;
      idle(6);
      bus_read(1'b0, 1, rd); check("t3_ferr_status", rd, 16'h2000);
      bus_write_stat(16'h2000);
      bus_read(1'b0, 1, rd); check("t3_ferr_cleared", rd, 16'h0000);

      // 4: overrun, fifth byte dropped
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1, FRAME);
      idle(4);
      bus_read(1'b0, 1, rd); check("t4_ovr_status", rd, 16'hC004);
      bus_read(1'b1, 1, rd); check("t4_rd1", rd, 16'h0001);
      bus_read(1'b1, 1, rd); check("t4_rd2", rd, 16'h0002);
      bus_read(1'b1, 1, rd); check("t4_rd3", rd, 16'h0003);
      bus_read(1'b1, 1, rd); check("t4_rd4", rd, 16'h0004);
      bus_read(1'b0, 1, rd); check("t4_status_drained", rd, 16'h4000);
      bus_write_stat(16'h4000);
      bus_read(1'b0, 1, rd); check("t4_ovr_cleared", rd, 16'h0000);

      // 5a: a 4-clk read pops once
      send_frame(8'h11, 1'b1, -1, FRAME);
      send_frame(8'h22, 1'b1, -1, FRAME);
      idle(4);
      bus_read(1'b0, 1, rd); check("t5_level2", rd, 16'h8002);
      bus_read(1'b1, 4, rd); check("t5_long_read", rd, 16'h0011);
      bus_read(1'b0, 1, rd); check("t5_level1", rd, 16'h8001);
      bus_read(1'b1, 1, rd); check("t5_rd22", rd, 16'h0022);
      bus_read(1'b0, 1, rd); check("t5_empty", rd, 16'h0000);

      // 5b: push on a full FIFO in the same cycle as a pop -> no overrun
      for (int i = 0; i < 4; i++) send_frame(8'h21 + 8'(i), 1'b1, -1, FRAME);
      idle(2);
      bus_read(1'b0, 1, rd); check("t5_full", rd, 16'h8004);
      send_frame(8'h25, 1'b1, PUSH_CYC, FRAME);
      check("t5_collide_pop", pop_dat, 16'h0021);
      idle(4);
      bus_read(1'b0, 1, rd); check("t5_collide_status", rd, 16'h8004);
      for (int i = 0; i < 4; i++) begin
         bus_read(1'b1, 1, rd); check("t5_collide_rd", rd, 16'h0022 + 16'(i));
      end
      bus_read(1'b0, 1, rd); check("t5_collide_empty", rd, 16'h0000);

      // 6: reset mid-frame
      send_frame(8'h77, 1'b1, -1, FRAME);
      idle(4);
      bus_read(1'b0, 1, rd); check("t6_pre_status", rd, 16'h8001);
      send_frame(8'hFF, 1'b1, -1, 4 * BIT_T);
      #1 reset_b = 1'b0;
      idle(3);
      #1 rxd = 1'b1; reset_b = 1'b1;
      idle(3 * BIT_T);
      bus_read(1'b0, 1, rd); check("t6_post_reset_status", rd, 16'h0000);
      send_frame(8'h5A, 1'b1, -1, FRAME);
      idle(4);
      bus_read(1'b0, 1, rd); check("t6_5a_status", rd, 16'h8001);
      bus_read(1'b1, 1, rd); check("t6_5a_data", rd, 16'h005A);
      bus_read(1'b0, 1, rd); check("t6_final_status", rd, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
